// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED bank arbiter.
//
// Contents:
//   state_t      - arbiter FSM states (IDLE, GRANT, GAP)
//   IDLE_PATTERN - MSB-only pattern shown while nobody owns the bank,
//                  stored MSB-aligned so any bank width up to
//                  MAX_LED_WIDTH can take its top slice
//   rr_pick_t    - result of a round-robin pick (index + one-hot)
//   rr_pick()    - round-robin search starting just above the pointer
package led_arb_pkg;

    localparam int MAX_REQ       = 8;
    localparam int MAX_LED_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    localparam logic [MAX_LED_WIDTH-1:0] IDLE_PATTERN =
        {1'b1, {(MAX_LED_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [2:0]         idx;
        logic [MAX_REQ-1:0] onehot;
    } rr_pick_t;

    // Scans ptr+1, ptr+2, ... with wrap-around at num_req. The pointer
    // position itself is checked last, so the previous owner only wins
    // again when nobody else is asking. An all-zero onehot means no request.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int                 num_req);
        rr_pick_t pick;
        int       idx;
        pick = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % num_req;
            if (k <= num_req && pick.onehot == '0 && req[idx]) begin
                pick.idx         = 3'(idx);
                pick.onehot[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/led_bank_arbiter_rr_select.sv
// Combinational round-robin picker.
//
// Ports:
//   req    [NUM_REQ-1:0] - request vector
//   ptr    [2:0]         - index of the most recent owner
//   onehot [NUM_REQ-1:0] - one-hot selection (zero when no request)
//   idx    [2:0]         - index of the selected requester
//   valid                - at least one request is pending
module rr_select
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [2:0]         idx,
    output logic               valid
);

    rr_pick_t pick;

    // Requests are zero-extended to the package width; the padding bits
    // can never be selected, so the upper onehot bits stay zero.
    always_comb begin
        pick   = rr_pick(MAX_REQ'(req), ptr, NUM_REQ);
        onehot = pick.onehot[NUM_REQ-1:0];
        idx    = pick.idx;
        valid  = |pick.onehot;
    end

endmodule

// File: rtl/led_bank_arbiter.sv
// Shares one LED bank between NUM_REQ requesters with round-robin
// arbitration, a minimum and a maximum ownership time, an idle indicator
// and a one-cycle blank separator between owners.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous, active-low reset
//   req        [NUM_REQ-1:0]           - held high while a requester wants the bank
//   pattern_in [NUM_REQ*LED_WIDTH-1:0] - requester i drives [i*LED_WIDTH +: LED_WIDTH]
//   gnt        [NUM_REQ-1:0]           - registered one-hot grant
//   owner      [2:0]                   - current owner, meaningful while busy
//   busy                               - bank is owned
//   LED        [LED_WIDTH-1:0]         - registered LED drive
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int LED_WIDTH = 8,
    parameter int MIN_HOLD  = 1000,
    parameter int MAX_HOLD  = 50000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*LED_WIDTH-1:0]   pattern_in,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [2:0]                     owner,
    output logic                           busy,
    output logic [LED_WIDTH-1:0]           LED
);

    localparam int             CW       = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  MIN_LAST = CW'(MIN_HOLD - 1);
    localparam logic [CW-1:0]  MAX_LAST = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0]  MAX_CNT  = CW'(MAX_HOLD);
    localparam logic [LED_WIDTH-1:0] IDLE_LED =
        IDLE_PATTERN[MAX_LED_WIDTH-1 -: LED_WIDTH];

    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [2:0]           ptr, ptr_next;
    logic [NUM_REQ-1:0]   gnt_next;
    logic [2:0]           owner_next;
    logic                 busy_next;
    logic [LED_WIDTH-1:0] led_next;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [2:0]           pick_idx;
    logic                 pick_valid;

    logic [LED_WIDTH-1:0] owner_pattern;
    logic                 owner_req;
    logic                 other_pending;
    logic                 release_now;
    logic                 preempt_now;

    rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_select (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // gnt is the one-hot form of owner while granted, so masking req with
    // gnt gives the owner's request without indexing by owner.
    always_comb begin
        owner_pattern = pattern_in[int'(owner)*LED_WIDTH +: LED_WIDTH];
        owner_req     = |(req & gnt);
        other_pending = |(req & ~gnt);
        release_now   = !owner_req && (cnt >= MIN_LAST);
        // Once the counter saturates at MAX_HOLD, >= keeps preemption armed.
        preempt_now   = other_pending && (cnt >= MAX_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 3'(NUM_REQ - 1);
            gnt   <= '0;
            owner <= '0;
            busy  <= 1'b0;
            LED   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ptr   <= ptr_next;
            gnt   <= gnt_next;
            owner <= owner_next;
            busy  <= busy_next;
            LED   <= led_next;
        end
    end

    // The LED shows the idle indicator in IDLE and blanks during GAP. On
    // the grant edge it still shows the idle indicator; from then on it
    // follows the owner's pattern one cycle late.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ptr_next   = ptr;
        gnt_next   = gnt;
        owner_next = owner;
        busy_next  = busy;
        led_next   = LED;
        case (state)
            IDLE: begin
                gnt_next  = '0;
                busy_next = 1'b0;
                led_next  = IDLE_LED;
                if (pick_valid) begin
                    state_next = GRANT;
                    gnt_next   = pick_onehot;
                    owner_next = pick_idx;
                    busy_next  = 1'b1;
                    ptr_next   = pick_idx;
                    cnt_next   = '0;
                end
            end
            GRANT: begin
                led_next = owner_pattern;
                if (cnt != MAX_CNT) begin
                    cnt_next = cnt + 1'b1;
                end
                if (release_now || preempt_now) begin
                    state_next = GAP;
                    gnt_next   = '0;
                    busy_next  = 1'b0;
                    led_next   = '0;
                end
            end
            GAP: begin
                state_next = IDLE;
                gnt_next   = '0;
                busy_next  = 1'b0;
                led_next   = IDLE_LED;
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                busy_next  = 1'b0;
                led_next   = '0;
            end
        endcase
    end

endmodule
